irq_sequencer: RTL and testbench

//  Interrupt controller for the program sequencer. Arbitrates N_IRQ level-sensitive requests
//  by fixed priority and saves the return fetch address. Steers the sequencer with a 1-cycle
//  jmp to the vector page (VEC_BASE + id), then back to the saved address on reti.

---
 rtl/irq_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_irq_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer: vectors the program sequencer to VEC_BASE+id and
// returns to the saved fetch address on reti. Define IRQ_NEST_EN to allow preemption.
module irq_sequencer #(
  parameter int          N_IRQ       = 4,
  parameter logic [3:0]  VEC_BASE    = 4'h8,
  parameter int          STACK_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  input  logic [7:0]       pm_addr,
  input  logic             reti,
  output logic             jmp,
  output logic [3:0]       jmp_addr,
  output logic             ret_jmp,
  output logic [7:0]       ret_addr,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [N_IRQ-1:0] in_service,
  output logic             busy
);

  localparam int IW = 3;
`ifdef IRQ_NEST_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  // Without nesting only one return address is ever outstanding.
  localparam int DEPTH = 1 + 0 * STACK_DEPTH;
`endif
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VECTOR  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] ack_q, ack_d;
  logic            jmp_q, jmp_d;
  logic [3:0]      jmp_addr_q, jmp_addr_d;
  logic            ret_jmp_q, ret_jmp_d;
  logic [7:0]      ret_addr_q, ret_addr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      addr_stk_q [DEPTH];
  logic [7:0]      addr_stk_d [DEPTH];
  logic [IW-1:0]   id_stk_q [DEPTH];
  logic [IW-1:0]   id_stk_d [DEPTH];

  logic [N_IRQ-1:0] eligible;
  logic [IW-1:0]    winner;
  logic [PW-1:0]    top_idx;
  logic [7:0]       top_addr;
  logic [IW-1:0]    top_id;
  logic             preempt;
  logic             do_push;

  assign eligible = irq_req & ~mask_q & ~in_service_q;

  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IW'(i);
    end
  end

  always_comb begin
    top_idx  = ptr_q - PW'(1);
    top_addr = '0;
    top_id   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i) == top_idx) begin
        top_addr = addr_stk_q[i];
        top_id   = id_stk_q[i];
      end
    end
  end

`ifdef IRQ_NEST_EN
  // Only a strictly higher-priority request may interrupt, and only if a slot is free.
  assign preempt = (|eligible) && (winner < top_id) && (ptr_q < PW'(DEPTH));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_we ? mask_din : mask_q;
    in_service_d = in_service_q;
    ack_d        = '0;
    jmp_d        = 1'b0;
    jmp_addr_d   = '0;
    ret_jmp_d    = 1'b0;
    ret_addr_d   = '0;
    ptr_d        = ptr_q;
    addr_stk_d   = addr_stk_q;
    id_stk_d     = id_stk_q;
    do_push      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) do_push = 1'b1;
      end
      ST_VECTOR: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti) begin
          state_d      = ST_RETURN;
          ret_jmp_d    = 1'b1;
          ret_addr_d   = top_addr;
          in_service_d = in_service_q & ~(N_IRQ'(1) << top_id);
          ptr_d        = ptr_q - PW'(1);
        end else if (preempt) begin
          do_push = 1'b1;
        end
      end
      ST_RETURN: begin
        state_d = (ptr_q != '0) ? ST_SERVICE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are prepared on the edge entering VECTOR.
    if (do_push) begin
      state_d      = ST_VECTOR;
      jmp_d        = 1'b1;
      jmp_addr_d   = VEC_BASE + 4'(winner);
      ack_d        = N_IRQ'(1) << winner;
      in_service_d = in_service_q | (N_IRQ'(1) << winner);
      ptr_d        = ptr_q + PW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (PW'(i) == ptr_q) begin
          addr_stk_d[i] = pm_addr;
          id_stk_d[i]   = winner;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= '1;
      in_service_q <= '0;
      ack_q        <= '0;
      jmp_q        <= 1'b0;
      jmp_addr_q   <= '0;
      ret_jmp_q    <= 1'b0;
      ret_addr_q   <= '0;
      ptr_q        <= '0;
      addr_stk_q   <= '{default: '0};
      id_stk_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      ack_q        <= ack_d;
      jmp_q        <= jmp_d;
      jmp_addr_q   <= jmp_addr_d;
      ret_jmp_q    <= ret_jmp_d;
      ret_addr_q   <= ret_addr_d;
      ptr_q        <= ptr_d;
      addr_stk_q   <= addr_stk_d;
      id_stk_q     <= id_stk_d;
    end
  end

  assign jmp        = jmp_q;
  assign jmp_addr   = jmp_addr_q;
  assign ret_jmp    = ret_jmp_q;
  assign ret_addr   = ret_addr_q;
  assign irq_ack    = ack_q;
  assign in_service = in_service_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: expected jump/return events are queued by the
// stimulus and compared by a negedge monitor whenever jmp or ret_jmp is seen.
module tb_irq_sequencer;

  localparam int EW = 21;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_req = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_din = '0;
  logic [7:0] pm_addr = '0;
  logic       reti = 1'b0;
  logic       jmp;
  logic [3:0] jmp_addr;
  logic       ret_jmp;
  logic [7:0] ret_addr;
  logic [3:0] irq_ack;
  logic [3:0] in_service;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  irq_sequencer dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .mask_we(mask_we),
    .mask_din(mask_din), .pm_addr(pm_addr), .reti(reti), .jmp(jmp),
    .jmp_addr(jmp_addr), .ret_jmp(ret_jmp), .ret_addr(ret_addr),
    .irq_ack(irq_ack), .in_service(in_service), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ev_jmp(input logic [3:0] page, input logic [3:0] ack);
    return {1'b0, page, 8'h00, 4'h0, ack};
  endfunction

  function automatic logic [EW-1:0] ev_ret(input logic [7:0] addr);
    return {1'b1, 4'h0, addr, 8'h00};
  endfunction

  // Monitor: every jmp/ret_jmp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (jmp || ret_jmp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: jmp=%0b ret_jmp=%0b jmp_addr=%0h ret_addr=%0h at %0t",
                   jmp, ret_jmp, jmp_addr, ret_addr, $time);
        end else begin
          check("event", 32'({ret_jmp, jmp_addr, ret_addr, 4'h0, irq_ack}), 32'(exp_q.pop_front()));
          check("no_jmp_and_ret", 32'(jmp & ret_jmp), 32'd0);
        end
      end else begin
        check("quiet_outputs", 32'({jmp_addr, ret_addr, irq_ack}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of whole cycles from the current one until jmp is seen.
  task automatic wait_jmp(input int max_cycles, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (jmp) break;
      n++;
      if (n >= max_cycles) break;
    end
  endtask

  task automatic pulse_reti(input logic [7:0] exp_addr);
    exp_q.push_back(ev_ret(exp_addr));
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  int n;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_jmp", 32'(jmp), 32'd0);
    check("rst_ret_jmp", 32'(ret_jmp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    reset = 1'b0;
    irq_req = 4'b1111;
    repeat (3) tick();
    check("rst_mask_all_ones", 32'(busy), 32'd0);
    irq_req = 4'b0000;

    // Basic vector and return
    mask_we = 1'b1; mask_din = 4'b0000;
    tick();
    mask_we = 1'b0;
    irq_req = 4'b0100; pm_addr = 8'h23;
    exp_q.push_back(ev_jmp(4'hA, 4'b0100));
    wait_jmp(20, n);
    check("latency_irq2", 32'(n), 32'd1);
    check("in_service_set", 32'(in_service), 32'b0100);
    check("busy_vector", 32'(busy), 32'd1);
    tick();
    irq_req = 4'b0000;
    repeat (2) tick();
    check("service_hold", 32'(in_service), 32'b0100);
    pulse_reti(8'h23);
    @(negedge clk);
    check("in_service_clear", 32'(in_service), 32'd0);
    tick();
    @(negedge clk);
    check("idle_after_ret", 32'(busy), 32'd0);

    // Two requests: irq1 first, irq2 after irq1 returns
    tick();
    irq_req = 4'b0110; pm_addr = 8'h40;
    exp_q.push_back(ev_jmp(4'h9, 4'b0010));
    wait_jmp(20, n);
    check("latency_irq1", 32'(n), 32'd1);
    tick();
    irq_req = 4'b0100; pm_addr = 8'h50;
    repeat (2) tick();
    pulse_reti(8'h40);
    exp_q.push_back(ev_jmp(4'hA, 4'b0100));
    wait_jmp(20, n);
    check("latency_irq2_after_ret", 32'(n), 32'd2);
    tick();
    irq_req = 4'b0000;
    pulse_reti(8'h50);
    repeat (2) tick();

    // Masking; also exercises pm_addr 8'hff as the saved address
    mask_we = 1'b1; mask_din = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq_req = 4'b0001;
    repeat (4) tick();
    check("masked_no_service", 32'(busy), 32'd0);
    mask_we = 1'b1; mask_din = 4'b0000; pm_addr = 8'hff;
    tick();
    mask_we = 1'b0;
    exp_q.push_back(ev_jmp(4'h8, 4'b0001));
    wait_jmp(20, n);
    check("latency_unmask", 32'(n), 32'd1);
    tick();
    irq_req = 4'b0000;
    pulse_reti(8'hff);
    repeat (2) tick();

    // Higher-priority request during service of irq2
    irq_req = 4'b0100; pm_addr = 8'h31;
    exp_q.push_back(ev_jmp(4'hA, 4'b0100));
    wait_jmp(20, n);
    check("latency_outer", 32'(n), 32'd1);
    tick();
    irq_req = 4'b0001; pm_addr = 8'hA5;
`ifdef IRQ_NEST_EN
    exp_q.push_back(ev_jmp(4'h8, 4'b0001));
    wait_jmp(20, n);
    check("latency_preempt", 32'(n), 32'd1);
    check("nested_in_service", 32'(in_service), 32'b0101);
    tick();
    irq_req = 4'b0000;
    pulse_reti(8'hA5);
    @(negedge clk);
    check("inner_cleared", 32'(in_service), 32'b0100);
    tick();
    pulse_reti(8'h31);
    repeat (2) tick();
`else
    repeat (3) tick();
    check("no_preempt_busy", 32'(busy), 32'd1);
    check("no_preempt_in_service", 32'(in_service), 32'b0100);
    pulse_reti(8'h31);
    exp_q.push_back(ev_jmp(4'h8, 4'b0001));
    wait_jmp(20, n);
    check("latency_waiting_irq0", 32'(n), 32'd2);
    tick();
    irq_req = 4'b0000;
    pulse_reti(8'hA5);
    repeat (2) tick();
`endif
    check("idle_after_nest", 32'(busy), 32'd0);

    // reti while idle is ignored
    reti = 1'b1;
    tick();
    reti = 1'b0;
    repeat (2) tick();
    check("reti_idle_ignored", 32'(busy), 32'd0);

    // Reset in the middle of service
    irq_req = 4'b1000; pm_addr = 8'h77;
    exp_q.push_back(ev_jmp(4'hB, 4'b1000));
    wait_jmp(20, n);
    check("latency_irq3", 32'(n), 32'd1);
    tick();
    irq_req = 4'b0000;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_in_service", 32'(in_service), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outputs", 32'({jmp, ret_jmp, jmp_addr, ret_addr, irq_ack}), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    irq_req = 4'b0001;
    repeat (4) tick();
    check("post_rst_masked", 32'(busy), 32'd0);
    irq_req = 4'b0000;
    repeat (2) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
